mag_scheduler: RTL and testbench

- Time-shares one iterative magnitude engine, sqrt(x^2 + y^2), between NREQ requesters.
- Arbitration is round-robin. Each requester and the single result port use valid/ready handshakes.
- The squaring multiplier and the bit-serial square-root loop run as one shared multiplier, sequenced by an FSM.
- Sits between the pad-facing operand registers and the output mux of the top level.

---
 rtl/mag_pkg.sv | 25 ++
 rtl/mag_if.sv | 30 +++
 rtl/rr_arbiter.sv | 34 +++
 rtl/mag_scheduler.sv | 164 ++++++++++++++++
 tb/tb_mag_scheduler.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mag_pkg.sv
// Shared types and width helpers for the magnitude scheduler.
package mag_pkg;

    // Default build of the block; instances may override NREQ/W.
    localparam int unsigned NREQ_DEF = 4;
    localparam int unsigned W_DEF    = 8;

    localparam int unsigned ID_W  = (NREQ_DEF < 2) ? 1 : $clog2(NREQ_DEF);
    localparam int unsigned ACC_W = 2 * W_DEF + 1;
    localparam int unsigned RES_W = W_DEF + 1;

    typedef enum logic [2:0] {
        StIdle,
        StSqx,
        StSqy,
        StRoot,
        StResp
    } state_e;

    // Requester-index width, kept >= 1 so the id bus never collapses.
    function automatic int unsigned id_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mag_if.sv
// Requester and result handshake bundle for the magnitude scheduler.
interface mag_if
    import mag_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8
);

    logic [NREQ-1:0]             req_valid;
    logic [NREQ-1:0]             req_ready;
    logic [NREQ*W-1:0]           req_x;
    logic [NREQ*W-1:0]           req_y;
    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [id_width(NREQ)-1:0]   rsp_id;
    logic [W:0]                  rsp_mag;

    // Requester side plus the downstream result consumer.
    modport master (
        output req_valid, req_x, req_y, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_mag
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_x, req_y, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_mag
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr_i, wrapping.
module rr_arbiter
    import mag_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IdW = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IdW-1:0]  ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IdW-1:0]  idx_o
);

    logic           found;
    logic [IdW-1:0] cand;

    // Scan NREQ candidates starting at the pointer; the first valid one wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = IdW'((32'(ptr_i) + k) % NREQ);
            if (en_i && !found && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                idx_o         = cand;
                found         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mag_scheduler.sv
// Round-robin front end sharing one iterative sqrt(x^2 + y^2) engine.
module mag_scheduler
    import mag_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    mag_if.slave mag_bus,
    output logic busy
);

    localparam int unsigned IdW  = id_width(NREQ);
    localparam int unsigned AccW = 2 * W + 1;
    localparam int unsigned ResW = W + 1;
    localparam int unsigned MulW = 2 * ResW;
    localparam int unsigned NW   = $clog2(W + 1);

    state_e state_q, state_d;

    logic [W-1:0]    x_q, x_d;
    logic [W-1:0]    y_q, y_d;
    logic [IdW-1:0]  id_q, id_d;
    logic [IdW-1:0]  ptr_q, ptr_d;
    logic [AccW-1:0] acc_q, acc_d;
    logic [ResW-1:0] root_q, root_d;
    logic [NW-1:0]   n_q, n_d;
    logic [ResW-1:0] rsp_mag_q, rsp_mag_d;
    logic [IdW-1:0]  rsp_id_q, rsp_id_d;

    logic            arb_en;
    logic [NREQ-1:0] grant;
    logic [IdW-1:0]  grant_idx;
    logic            grant_any;
    logic [ResW-1:0] trial;
    logic [ResW-1:0] mul_op;
    logic [MulW-1:0] prod;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .req_i   (mag_bus.req_valid),
        .ptr_i   (ptr_q),
        .en_i    (arb_en),
        .grant_o (grant),
        .idx_o   (grant_idx)
    );

    assign grant_any = |grant;
    assign trial     = root_q | (ResW'(1) << n_q);

    // Single shared squarer: operand chosen by the step being executed.
    always_comb begin
        mul_op = '0;
        unique case (state_q)
            StSqx:   mul_op = {1'b0, x_q};
            StSqy:   mul_op = {1'b0, y_q};
            StRoot:  mul_op = trial;
            default: mul_op = '0;
        endcase
        prod = MulW'(mul_op) * MulW'(mul_op);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: everything stalls on !ena except draining a finished result.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (ena && grant_any) state_d = StSqx;
            StSqx:   if (ena) state_d = StSqy;
            StSqy:   if (ena) state_d = StRoot;
            StRoot:  if (ena && (n_q == '0)) state_d = StResp;
            StResp:  if (mag_bus.rsp_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        busy              = (state_q != StIdle);
        arb_en            = ena && (state_q == StIdle);
        mag_bus.req_ready = grant;
        mag_bus.rsp_valid = (state_q == StResp);
        mag_bus.rsp_mag   = rsp_mag_q;
        mag_bus.rsp_id    = rsp_id_q;
    end

    // Datapath next-state: capture, square/accumulate, then one root bit per cycle.
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        id_d      = id_q;
        ptr_d     = ptr_q;
        acc_d     = acc_q;
        root_d    = root_q;
        n_d       = n_q;
        rsp_mag_d = rsp_mag_q;
        rsp_id_d  = rsp_id_q;
        if (ena) begin
            case (state_q)
                StIdle: begin
                    if (grant_any) begin
                        x_d   = mag_bus.req_x[grant_idx*W +: W];
                        y_d   = mag_bus.req_y[grant_idx*W +: W];
                        id_d  = grant_idx;
                        ptr_d = (grant_idx == IdW'(NREQ - 1)) ? '0 : grant_idx + IdW'(1);
                    end
                end
                StSqx: acc_d = AccW'(prod);
                StSqy: begin
                    acc_d  = acc_q + AccW'(prod);
                    root_d = '0;
                    n_d    = NW'(W);
                end
                StRoot: begin
                    if (prod <= MulW'(acc_q)) root_d = trial;
                    if (n_q == '0) begin
                        rsp_mag_d = root_d;
                        rsp_id_d  = id_q;
                    end else begin
                        n_d = n_q - NW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers; reset drops any calculation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q       <= '0;
            y_q       <= '0;
            id_q      <= '0;
            ptr_q     <= '0;
            acc_q     <= '0;
            root_q    <= '0;
            n_q       <= '0;
            rsp_mag_q <= '0;
            rsp_id_q  <= '0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            id_q      <= id_d;
            ptr_q     <= ptr_d;
            acc_q     <= acc_d;
            root_q    <= root_d;
            n_q       <= n_d;
            rsp_mag_q <= rsp_mag_d;
            rsp_id_q  <= rsp_id_d;
        end
    end

endmodule

// File: tb/tb_mag_scheduler.sv
// Directed plus randomized bench for mag_scheduler against an arithmetic model.
module tb_mag_scheduler;
    import mag_pkg::*;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int LAT = W + 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b1;
    logic busy;

    mag_if #(.NREQ(N), .W(W)) bus ();

    mag_scheduler #(
        .NREQ (N),
        .W    (W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .mag_bus (bus),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int model_ptr = 0;
    int xs [N];
    int ys [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Largest r with r*r <= x^2 + y^2.
    function automatic int ref_mag(input int x, input int y);
        int s;
        int r;
        s = x * x + y * y;
        r = 0;
        while ((r + 1) * (r + 1) <= s) r++;
        return r;
    endfunction

    function automatic int ref_grant(input logic [N-1:0] mask);
        for (int k = 0; k < N; k++) begin
            if (mask[(model_ptr + k) % N]) return (model_ptr + k) % N;
        end
        return 0;
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < N; i++) begin
            bus.req_x[i*W +: W] = W'(xs[i]);
            bus.req_y[i*W +: W] = W'(ys[i]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 0);
        check({tag, "_rsp_id"}, 32'(bus.rsp_id), 0);
        check({tag, "_rsp_mag"}, 32'(bus.rsp_mag), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 0);
    endtask

    task automatic handshake();
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check("rsp_valid_drop", 32'(bus.rsp_valid), 0);
        check("idle_after_rsp", 32'(busy), 0);
    endtask

    // Present mask in IDLE, follow the accepted request to its result.
    task automatic issue(input logic [N-1:0] mask, input int stall_at, input bit hold_rsp,
                         input bit keep, output int exp_mag, output int exp_id);
        int g;
        int k;
        int lat;
        g = ref_grant(mask);
        drive_ops();
        bus.req_valid = mask;
        #1;
        check("req_ready_grant", 32'(bus.req_ready), 32'(1) << g);
        check("req_ready_onehot", 32'($countones(bus.req_ready)), 1);
        exp_mag   = ref_mag(xs[g], ys[g]);
        exp_id    = g;
        model_ptr = (g + 1) % N;
        @(posedge clk); #1;
        if (!keep) bus.req_valid = '0;
        check("req_ready_pulse", 32'(bus.req_ready), 0);
        check("busy_after_accept", 32'(busy), 1);
        lat = LAT + ((stall_at > 0) ? 5 : 0);
        k = 1;
        while (!bus.rsp_valid && k < 60) begin
            if (stall_at > 0 && k == stall_at) ena = 1'b0;
            if (stall_at > 0 && k == stall_at + 5) ena = 1'b1;
            @(posedge clk); #1;
            k++;
        end
        ena = 1'b1;
        check("latency", 32'(k), 32'(lat));
        check("rsp_mag", 32'(bus.rsp_mag), 32'(exp_mag));
        check("rsp_id", 32'(bus.rsp_id), 32'(exp_id));
        if (!hold_rsp) handshake();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int em;
        int ei;
        bit seen;
        int bx [4];
        int by [4];
        logic [N-1:0] mask;

        bx = '{255, 0, 255, 1};
        by = '{255, 0, 0, 1};
        for (int i = 0; i < N; i++) begin
            xs[i] = 0;
            ys[i] = 0;
        end
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        bus.req_x     = '0;
        bus.req_y     = '0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("reset");

        // Single request from requester 1: 3,4 -> 5.
        xs[1] = 3;
        ys[1] = 4;
        issue(4'b0010, 0, 1'b0, 1'b0, em, ei);
        check("first_mag_is_5", 32'(bus.rsp_mag), 5);

        // Boundary operands.
        for (int b = 0; b < 4; b++) begin
            xs[b] = bx[b];
            ys[b] = by[b];
            issue(N'(1 << b), 0, 1'b0, 1'b0, em, ei);
        end

        // All requesters held valid from reset: strict rotation 0,1,2,3,0.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_ptr = 0;
        for (int s = 0; s < 5; s++) begin
            for (int i = 0; i < N; i++) begin
                xs[i] = int'($urandom_range(0, 255));
                ys[i] = int'($urandom_range(0, 255));
            end
            issue(4'b1111, 0, 1'b0, 1'b1, em, ei);
            check("rr_order", 32'(ei), 32'(s % N));
        end
        bus.req_valid = '0;

        // Backpressure: result must stay frozen and nothing new granted.
        xs[3] = int'($urandom_range(0, 255));
        ys[3] = int'($urandom_range(0, 255));
        issue(4'b1000, 0, 1'b1, 1'b0, em, ei);
        bus.req_valid = 4'b1111;
        repeat (20) begin
            @(posedge clk); #1;
            check("bp_rsp_valid", 32'(bus.rsp_valid), 1);
            check("bp_rsp_mag", 32'(bus.rsp_mag), 32'(em));
            check("bp_rsp_id", 32'(bus.rsp_id), 32'(ei));
            check("bp_req_ready", 32'(bus.req_ready), 0);
        end
        bus.req_valid = '0;
        handshake();

        // Reset during ROOT aborts the job.
        xs[2] = 6;
        ys[2] = 8;
        drive_ops();
        bus.req_valid = 4'b0100;
        #1;
        check("abort_grant", 32'(bus.req_ready), 32'(4'b0100));
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_ptr = 0;
        check_reset_outputs("abort");
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) seen = 1'b1;
        end
        check("abort_no_rsp", 32'(seen), 0);
        for (int i = 0; i < N; i++) begin
            xs[i] = 5;
            ys[i] = 12;
        end
        issue(4'b1111, 0, 1'b0, 1'b0, em, ei);
        check("post_abort_mag_13", 32'(bus.rsp_mag), 13);

        // ena low suppresses grants, and a stall in SQY shifts the result by 5.
        bus.req_valid = 4'b0100;
        ena = 1'b0;
        #1;
        check("ena_low_no_ready", 32'(bus.req_ready), 0);
        ena = 1'b1;
        xs[2] = 8;
        ys[2] = 15;
        issue(4'b0100, 2, 1'b0, 1'b0, em, ei);

        // Randomized masks and operands.
        repeat (12) begin
            for (int i = 0; i < N; i++) begin
                xs[i] = int'($urandom_range(0, 255));
                ys[i] = int'($urandom_range(0, 255));
            end
            mask = N'($urandom_range(1, (1 << N) - 1));
            issue(mask, 0, 1'b0, 1'b0, em, ei);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
